// File: rtl/match_controller.sv
`timescale 1ns/1ps
// Round/match sequencer for the two-player fighter: start, countdown, fight,
// round end and match end, with the round clock and best-of-N scoring.
module match_controller #(
    parameter int TICKS_PER_SEC     = 20,
    parameter int ROUND_SECONDS     = 99,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int ROUNDS_TO_WIN     = 2,
    parameter int KO_HOLD_TICKS     = 40,
    parameter int RESET_TICKS       = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       abort,
    input  logic [8:0] health_1,
    input  logic [8:0] health_2,
    output logic       round_reset,
    output logic       freeze,
    output logic [2:0] phase,
    output logic [1:0] countdown,
    output logic [6:0] round_time,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] round_winner,
    output logic [1:0] match_winner
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RESET      = 3'd1,
        S_COUNTDOWN  = 3'd2,
        S_FIGHT      = 3'd3,
        S_ROUND_END  = 3'd4,
        S_MATCH_OVER = 3'd5
    } state_t;

    localparam int CD_TICKS = COUNTDOWN_SECONDS * TICKS_PER_SEC;
    localparam int MAX_A    = (CD_TICKS > KO_HOLD_TICKS) ? CD_TICKS : KO_HOLD_TICKS;
    localparam int MAX_B    = (RESET_TICKS > TICKS_PER_SEC) ? RESET_TICKS : TICKS_PER_SEC;
    localparam int TMAX     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW       = $clog2(TMAX + 1);

    localparam logic [TW-1:0] RESET_LAST = TW'(RESET_TICKS - 1);
    localparam logic [TW-1:0] CD_LAST    = TW'(CD_TICKS - 1);
    localparam logic [TW-1:0] SEC_LAST   = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(KO_HOLD_TICKS - 1);
    localparam logic [TW-1:0] TPS        = TW'(TICKS_PER_SEC);
    localparam logic [1:0]    TARGET     = 2'(ROUNDS_TO_WIN);
    localparam logic [1:0]    CD_START   = 2'(COUNTDOWN_SECONDS);
    localparam logic [6:0]    ROUND_INIT = 7'(ROUND_SECONDS);

    state_t        state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [1:0]    btn_sync;
    logic          btn_prev;
    logic          start_pending;
    logic          start_edge, start_req;
    logic [6:0]    time_n;
    logic [1:0]    p1_n, p2_n, rw_n, mw_n, winner;
    logic          rr_n, fr_n;
    logic [1:0]    cd_n;

    // Raw button is asynchronous to clk; synchronise before edge detection.
    assign start_edge = btn_sync[1] & ~btn_prev;
    assign start_req  = start_pending | start_edge;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            tcnt          <= '0;
            btn_sync      <= '0;
            btn_prev      <= 1'b0;
            start_pending <= 1'b0;
            round_time    <= ROUND_INIT;
            p1_rounds     <= '0;
            p2_rounds     <= '0;
            round_winner  <= '0;
            match_winner  <= '0;
            phase         <= S_IDLE;
            round_reset   <= 1'b1;
            freeze        <= 1'b1;
            countdown     <= '0;
        end else begin
            btn_sync <= {btn_sync[0], start_btn};
            btn_prev <= btn_sync[1];
            if (abort || tick)
                start_pending <= 1'b0;
            else if (start_edge)
                start_pending <= 1'b1;
            state        <= state_n;
            tcnt         <= tcnt_n;
            round_time   <= time_n;
            p1_rounds    <= p1_n;
            p2_rounds    <= p2_n;
            round_winner <= rw_n;
            match_winner <= mw_n;
            phase        <= state_n;
            round_reset  <= rr_n;
            freeze       <= fr_n;
            countdown    <= cd_n;
        end
    end

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        time_n  = round_time;
        p1_n    = p1_rounds;
        p2_n    = p2_rounds;
        rw_n    = round_winner;
        mw_n    = match_winner;
        winner  = 2'b00;
        if (tick) begin
            tcnt_n = tcnt + 1'b1;
            if (abort) begin
                state_n = S_IDLE;
            end else begin
                case (state)
                    S_IDLE:      if (start_req) state_n = S_RESET;
                    S_RESET:     if (tcnt == RESET_LAST) state_n = S_COUNTDOWN;
                    S_COUNTDOWN: if (tcnt == CD_LAST) state_n = S_FIGHT;
                    S_FIGHT: begin
                        if (tcnt == SEC_LAST) begin
                            tcnt_n = '0;
                            if (round_time != 7'd0) time_n = round_time - 7'd1;
                        end
                        // KO is checked before the clock so a simultaneous expiry resolves as KO.
                        if (health_1 == 9'd0 || health_2 == 9'd0) begin
                            state_n = S_ROUND_END;
                            winner  = {health_1 == 9'd0, health_2 == 9'd0};
                        end else if (time_n == 7'd0) begin
                            state_n = S_ROUND_END;
                            if (health_1 > health_2)      winner = 2'b01;
                            else if (health_2 > health_1) winner = 2'b10;
                            else                          winner = 2'b11;
                        end
                    end
                    S_ROUND_END: begin
                        if (tcnt == HOLD_LAST) begin
                            if (p1_rounds >= TARGET || p2_rounds >= TARGET) begin
                                state_n = S_MATCH_OVER;
                                mw_n    = {p2_rounds >= TARGET, p1_rounds >= TARGET};
                            end else begin
                                state_n = S_RESET;
                            end
                        end
                    end
                    S_MATCH_OVER: if (start_req) state_n = S_IDLE;
                    default:      state_n = S_IDLE;
                endcase
            end
            if (state_n != state || state_n == S_IDLE || state_n == S_MATCH_OVER)
                tcnt_n = '0;
            if (state_n == S_RESET && state != S_RESET) begin
                time_n = ROUND_INIT;
                rw_n   = '0;
            end
            if (state_n == S_ROUND_END && state == S_FIGHT) begin
                rw_n = winner;
                if (winner[0] && p1_rounds != 2'd3) p1_n = p1_rounds + 2'd1;
                if (winner[1] && p2_rounds != 2'd3) p2_n = p2_rounds + 2'd1;
            end
            if (state_n == S_IDLE) begin
                p1_n = '0;
                p2_n = '0;
                rw_n = '0;
                mw_n = '0;
            end
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        rr_n = 1'b0;
        fr_n = 1'b1;
        cd_n = '0;
        case (state_n)
            S_IDLE, S_RESET: rr_n = 1'b1;
            S_COUNTDOWN:     cd_n = CD_START - 2'(tcnt_n / TPS);
            S_FIGHT:         fr_n = 1'b0;
            default:         ;
        endcase
    end

endmodule

// File: doc/match_controller.md
# match_controller

Round/match sequencer for the two-player fighter. It sits between the game-tick domain (CLK_20Hz enable), the health manager and the physics engines, and it decides when play is frozen, when the arena is reset, and when rounds and the match end. It drives the shared round reset and input-freeze for both players, a countdown and round clock for the status bar/7-seg, and best-of-N scoring with the final winner.

## Interface
Parameters:
- TICKS_PER_SEC, 20, game ticks per displayed second
- ROUND_SECONDS, 99, round clock start value (≤127)
- COUNTDOWN_SECONDS, 3, pre-fight countdown length (1–3)
- ROUNDS_TO_WIN, 2, round wins needed for the match (1–3)
- KO_HOLD_TICKS, 40, ticks held in ROUND_END before advancing
- RESET_TICKS, 2, ticks round_reset is held in RESET

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- tick  in  1  one-clk pulse per game tick
- start_btn  in  1  raw start level (btnC)
- abort  in  1  level; forces return to IDLE
- health_1 / health_2  in  9  current HP, 0 = KO
- round_reset  out  1  level reset to physics/health engines
- freeze  out  1  ignore player inputs and attacks
- phase  out  3  0 IDLE, 1 RESET, 2 COUNTDOWN, 3 FIGHT, 4 ROUND_END, 5 MATCH_OVER
- countdown  out  2  digit shown during COUNTDOWN, else 0
- round_time  out  7  seconds remaining
- p1_rounds / p2_rounds  out  2  rounds won
- round_winner  out  2  01 P1, 10 P2, 11 draw, 00 none
- match_winner  out  2  same encoding; nonzero only in MATCH_OVER

## Operation
- start_btn rising edge (clk-domain edge detect) sets start_pending. The flag clears when a tick consumes it, and also on abort/reset.
- State changes only on cycles with tick=1. A per-state tick counter (tcnt) clears on every state entry.
- IDLE: round_reset=1, freeze=1. Scores, round_winner and match_winner are cleared. start_pending → RESET.
- RESET: round_reset=1, freeze=1, round_time=ROUND_SECONDS. Exits to COUNTDOWN on the RESET_TICKS-th tick in state.
- COUNTDOWN: round_reset=0, freeze=1, countdown = COUNTDOWN_SECONDS − tcnt/TICKS_PER_SEC. Exits to FIGHT after COUNTDOWN_SECONDS×TICKS_PER_SEC ticks.
- FIGHT: freeze=0. The sub-second counter wraps at TICKS_PER_SEC and round_time decrements on each wrap. Per-tick checks, evaluated in this order:
  - KO: if health_1==0 or health_2==0, go to ROUND_END. Winner is the survivor; both zero → 11.
  - Timeout: round_time reaches 0 → ROUND_END. Higher HP wins; equal → 11.
- Scoring on entry to ROUND_END: the winner's count increments. A draw increments both. Counts saturate at 3.
- ROUND_END: freeze=1. After KO_HOLD_TICKS ticks:
  - If any count ≥ ROUNDS_TO_WIN → MATCH_OVER. match_winner = set of players at/over target; both → 11.
  - Otherwise → RESET. round_winner clears on RESET entry.
- MATCH_OVER: freeze=1, round_reset=0 (final pose stays visible). start_pending → IDLE.
- abort=1 on a tick in any state → IDLE. Abort takes priority over every other transition.
- start edges seen outside IDLE/MATCH_OVER are discarded on the next tick.

## Timing
- All outputs are registered and update one clk after the deciding tick cycle.
- Values after reset_n=0: phase=IDLE, round_reset=1, freeze=1, countdown=0, round_time=ROUND_SECONDS, all scores/winners=0, start_pending=0.
- reset_n low mid-round behaves exactly like power-up. It takes priority over tick and abort.
- Start-to-FIGHT latency: 1 tick (IDLE→RESET) + RESET_TICKS + COUNTDOWN_SECONDS×TICKS_PER_SEC ticks.
- A KO on the same tick that round_time hits 0 resolves as KO.
- Health is sampled only on tick cycles; HP changes between ticks are ignored.
- round_time never underflows; it holds at 0 outside FIGHT until RESET reloads it.

## Test plan
Bench parameters: TICKS_PER_SEC=4, ROUND_SECONDS=5, COUNTDOWN_SECONDS=3, KO_HOLD_TICKS=8, RESET_TICKS=2.
- Start sequence: start edge in IDLE → phase 1 after the next tick; after 2 more ticks phase 2 with countdown 3→2→1, 4 ticks each; after 12 ticks phase 3 with freeze=0 and round_reset=0.
- KO: health_2=0 during FIGHT → phase 4, round_winner=01, p1_rounds=1. After 8 ticks, phase 1 with round_winner=00.
- Timeout: HP 50/80 held → round_time 5→0 over 20 ticks → round_winner=10, p2_rounds=1. Equal HP → 11, both counts +1.
- Match end and double KO: P1 wins two rounds → phase 5, match_winner=01; start edge → IDLE with scores 0. At 1–1, both HP=0 on one tick → both counts 2, match_winner=11.
- Abort/reset: abort on a tick in FIGHT → IDLE next cycle with round_reset=1 and scores 0. reset_n low for 1 clk mid-COUNTDOWN → all reset values.
- Stray start: start edge during FIGHT → no state change; pending flag is cleared by the next tick.
